spi_slave_tx_mlane: RTL and testbench
=====================================

# spi_slave_tx_mlane

Parametrised next-generation SPI slave transmit shifter: serialises DATA_WIDTH-bit words onto 1, 2 or 4 data lanes. A one-word staging buffer with a valid/ready handshake lets the upstream controller supply the next word while the current one is shifting, so consecutive words stream without gaps. It sits between the SPI slave controller (word source, transfer length) and the sdo pads, in the sclk domain, and is held in reset while chip-select is deasserted.

## Interface
- DATA_WIDTH, 32: word width in bits; multiple of 4, minimum 8.
- CNT_WIDTH, 8: width of the cycle counter and target.
- TRGT_RST, 7: target value loaded at reset.

- sclk  in  1  clock; all state updates on the rising edge.
- cs  in  1  asynchronous, active-high reset (chip-select deasserted).
- mode_in  in  2  lane mode: 00 single, 01 dual, 10 quad, 11 treated as single.
- counter_in  in  CNT_WIDTH  cycles per word minus 1.
- counter_in_upd  in  1  start or restart a transfer and load counter_in as the target.
- data_in  in  DATA_WIDTH  next word, MSB first.
- data_valid  in  1  data_in is valid.
- data_ready  out  1  staging buffer can accept a word.
- sdo  out  4  serial data lanes.
- done  out  1  word-boundary pulse.
- underrun  out  1  sticky underrun flag; present only with the macro below.

## Operation
- State: shift register sreg, counter cnt, target trgt, registered lane mode mode_q, buffer buf with buf_valid, and a state machine with states IDLE and SHIFT.
- Reset (cs=1, immediate, async): IDLE, cnt=0, trgt=TRGT_RST, sreg=0, buf_valid=0, mode_q=single, underrun=0.
- Buffer write: the buffer captures data_in when data_valid && data_ready.
- data_ready = !buf_valid || consume, where consume means the buffer is loaded into sreg this cycle.
- A write and a consume in the same cycle leave buf_valid=1 holding the new word.
- counter_in_upd in any state is a start:
  - trgt<=counter_in, cnt<=0, mode_q<=mode_in, state<=SHIFT.
  - If buf_valid, sreg<=buf (consume).
  - Otherwise sreg<=0 and this is an underrun.
  - No shift happens in the start cycle.
- SHIFT, cnt!=trgt: cnt<=cnt+1; sreg shifts left by the lane count (1/2/4), zero-filled.
- SHIFT, cnt==trgt (boundary): done=1 and cnt<=0.
  - If buf_valid: sreg<=buf (consume) and stay in SHIFT.
  - Otherwise: sreg shifts, state<=IDLE.
- IDLE without counter_in_upd: all state holds.
- sdo mapping from sreg, with W=DATA_WIDTH:
  - single: sdo={3'b0, sreg[W-1]}.
  - dual: sdo={2'b0, sreg[W-1], sreg[W-2]}.
  - quad: sdo=sreg[W-1:W-4].
- Bits per word = (trgt+1) × lanes. The controller keeps this value ≤ W; excess cycles shift out zeros.
- cnt wrap: cnt returns to 0 only at the boundary. trgt=0 gives a boundary on every SHIFT cycle.

## Timing
- sdo and done are combinational from registered state only (mode_q, sreg, state, cnt, trgt); no input-to-output path.
- done = (state==SHIFT) && (cnt==trgt).
- First bit on sdo: the cycle after the counter_in_upd edge.
- A word occupies trgt+1 cycles; done is high in the last one.
- Back-to-back: the next word's first bit follows the boundary cycle directly.
- counter_in_upd during SHIFT aborts the current word; the remaining bits are discarded.
- Reset values: sdo=0, done=0, data_ready=1, underrun=0.
- cs asserted mid-word clears everything asynchronously, including the buffered word.

## Configuration
- SPI_SLAVE_TX_UNDERRUN_EN defined:
  - The underrun port exists.
  - It is set on a start with buf_valid=0 and stays set until cs resets it.
- Macro undefined:
  - The underrun port and flop are absent.
  - Underrun starts still shift out zeros.

## Test plan
- Single lane: write 0xA5000000, upd with counter_in=7 → sdo[0]=1,0,1,0,0,1,0,1 over 8 cycles; done only in the 8th; IDLE afterwards; sdo[3:1]=0 throughout.
- Quad: write 0x12345678, mode 10, upd with counter_in=7 → sdo=1,2,3,4,5,6,7,8; done in cycle 8.
- Dual streaming: write 0xFFFF0000, upd with counter_in=15, then write 0x0000FFFF during word 1 → 32 contiguous cycles; done in cycles 16 and 32; data_ready low from the second write until cycle 16.
- Underrun: upd with an empty buffer → sdo=0 for trgt+1 cycles; underrun=1 with the macro, port absent without it.
- Reset mid-word: cs=1 at cnt=3 with buf_valid=1 → sdo=0, done=0, data_ready=1 at once; the next start with no new write underruns.
- Restart: upd with counter_in=3 at cnt=5 of word 0xF0F0F0F0 → the buffered word starts next cycle; done after 4 cycles.

Source files
------------

// File: rtl/spi_slave_tx_mlane.sv
// spi_slave_tx_mlane
//
// SPI slave transmit shifter. Each DATA_WIDTH-bit word goes out MSB first on
// 1, 2 or 4 lanes. A one-word staging buffer with a valid/ready handshake lets
// the next word be written while the current one shifts, so consecutive words
// stream without a gap. Everything runs in the sclk domain. Chip-select
// deassertion (cs=1) resets the block asynchronously.
//
// Ports:
//   sclk           in   clock; all state updates on the rising edge
//   cs             in   asynchronous active-high reset
//   mode_in        in   lane mode: 00 single, 01 dual, 10 quad, 11 single
//   counter_in     in   cycles per word minus 1
//   counter_in_upd in   start or restart a transfer and load counter_in as target
//   data_in        in   next word, MSB first
//   data_valid     in   data_in is valid
//   data_ready     out  staging buffer can accept a word
//   sdo            out  serial data lanes
//   done           out  word-boundary pulse
//   underrun       out  sticky underrun flag (only with SPI_SLAVE_TX_UNDERRUN_EN)
//
// Build option: define SPI_SLAVE_TX_UNDERRUN_EN to add the underrun port and flag.

module spi_slave_tx_mlane #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned TRGT_RST   = 7
) (
    input  logic                  sclk,
    input  logic                  cs,
    input  logic [1:0]            mode_in,
    input  logic [CNT_WIDTH-1:0]  counter_in,
    input  logic                  counter_in_upd,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [3:0]            sdo,
    output logic                  done
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    ,
    output logic                  underrun
`endif
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  trgt_q, trgt_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [DATA_WIDTH-1:0] buf_q;
    logic                  buf_valid_q;
    logic [DATA_WIDTH-1:0] sreg_shifted;
    logic                  consume;
    logic                  boundary;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    logic                  start_empty;
    logic                  underrun_q;
`endif

    // Shift by the lane count of the registered mode; zeros fill from the right.
    always_comb begin
        sreg_shifted = sreg_q << 1;
        case (mode_q)
            2'b01:   sreg_shifted = sreg_q << 2;
            2'b10:   sreg_shifted = sreg_q << 4;
            default: sreg_shifted = sreg_q << 1;
        endcase
    end

    assign boundary = (state_q == StShift) && (cnt_q == trgt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trgt_d  = trgt_q;
        mode_d  = mode_q;
        sreg_d  = sreg_q;
        consume = 1'b0;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        start_empty = 1'b0;
`endif
        if (counter_in_upd) begin
            // Start (or abort-and-restart); no shift in this cycle.
            trgt_d  = counter_in;
            cnt_d   = '0;
            mode_d  = mode_in;
            state_d = StShift;
            if (buf_valid_q) begin
                sreg_d  = buf_q;
                consume = 1'b1;
            end else begin
                sreg_d = '0;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
                start_empty = 1'b1;
`endif
            end
        end else if (state_q == StShift) begin
            if (!boundary) begin
                cnt_d  = cnt_q + CNT_WIDTH'(1);
                sreg_d = sreg_shifted;
            end else begin
                cnt_d = '0;
                if (buf_valid_q) begin
                    sreg_d  = buf_q;
                    consume = 1'b1;
                end else begin
                    sreg_d  = sreg_shifted;
                    state_d = StIdle;
                end
            end
        end
    end

    assign data_ready = !buf_valid_q || consume;

    always_ff @(posedge sclk or posedge cs) begin
        if (cs) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            trgt_q  <= CNT_WIDTH'(TRGT_RST);
            mode_q  <= 2'b00;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trgt_q  <= trgt_d;
            mode_q  <= mode_d;
            sreg_q  <= sreg_d;
        end
    end

    // A write in the same cycle as a consume refills the buffer with the new word.
    always_ff @(posedge sclk or posedge cs) begin
        if (cs) begin
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
        end else if (data_valid && data_ready) begin
            buf_q       <= data_in;
            buf_valid_q <= 1'b1;
        end else if (consume) begin
            buf_valid_q <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    always_ff @(posedge sclk or posedge cs) begin
        if (cs) begin
            underrun_q <= 1'b0;
        end else if (start_empty) begin
            underrun_q <= 1'b1;
        end
    end

    assign underrun = underrun_q;
`endif

    always_comb begin
        sdo = {3'b000, sreg_q[DATA_WIDTH-1]};
        case (mode_q)
            2'b01:   sdo = {2'b00, sreg_q[DATA_WIDTH-1], sreg_q[DATA_WIDTH-2]};
            2'b10:   sdo = sreg_q[DATA_WIDTH-1:DATA_WIDTH-4];
            default: sdo = {3'b000, sreg_q[DATA_WIDTH-1]};
        endcase
    end

    assign done = boundary;

endmodule

// File: tb/tb_spi_slave_tx_mlane.sv
// Testbench for spi_slave_tx_mlane: directed scenarios followed by random
// traffic, all checked against a word/bit-index reference model.

module tb_spi_slave_tx_mlane;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 8;

    logic          sclk = 1'b0;
    logic          cs;
    logic [1:0]    mode_in;
    logic [CW-1:0] counter_in;
    logic          counter_in_upd;
    logic [W-1:0]  data_in;
    logic          data_valid;
    logic          data_ready;
    logic [3:0]    sdo;
    logic          done;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    logic          underrun;
`endif

    spi_slave_tx_mlane #(
        .DATA_WIDTH(W),
        .CNT_WIDTH (CW),
        .TRGT_RST  (7)
    ) dut (
        .sclk          (sclk),
        .cs            (cs),
        .mode_in       (mode_in),
        .counter_in    (counter_in),
        .counter_in_upd(counter_in_upd),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .sdo           (sdo),
        .done          (done)
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        ,
        .underrun      (underrun)
`endif
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: the current word, the index k of the lane-group now on
    // sdo, the word length, and a queue standing in for the staging buffer.
    logic [W-1:0] m_word;
    int           m_k;
    int           m_trgt;
    int           m_lanes;
    bit           m_active;
    bit           m_und;
    logic [W-1:0] m_q[$];

    function automatic int lanes_of(input logic [1:0] m);
        if (m == 2'b01) return 2;
        if (m == 2'b10) return 4;
        return 1;
    endfunction

    function automatic logic [3:0] exp_sdo();
        logic [W-1:0] t;
        t = m_word << (m_k * m_lanes);
        if (m_lanes == 4) return t[W-1:W-4];
        if (m_lanes == 2) return {2'b00, t[W-1:W-2]};
        return {3'b000, t[W-1]};
    endfunction

    function automatic bit exp_done();
        return m_active && (m_k == m_trgt);
    endfunction

    function automatic bit m_takes_buf();
        if (m_q.size() == 0) return 1'b0;
        if (counter_in_upd) return 1'b1;
        return exp_done();
    endfunction

    task automatic model_reset();
        m_word   = '0;
        m_k      = 0;
        m_trgt   = 7;
        m_lanes  = 1;
        m_active = 1'b0;
        m_und    = 1'b0;
        m_q.delete();
    endtask

    task automatic check_state_outputs();
        check_eq("sdo", {60'd0, sdo}, {60'd0, exp_sdo()});
        check_eq("done", {63'd0, done}, {63'd0, exp_done()});
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        check_eq("underrun", {63'd0, underrun}, {63'd0, m_und});
`endif
    endtask

    // One clock with the inputs currently driven; entered and left at posedge+1.
    task automatic tick();
        bit           take;
        bit           ready;
        bit           wr;
        logic [W-1:0] nxt;
        #1;
        take  = m_takes_buf();
        ready = (m_q.size() == 0) || take;
        wr    = data_valid && ready;
        check_eq("data_ready", {63'd0, data_ready}, {63'd0, ready});
        @(posedge sclk);
        nxt = '0;
        if (take) nxt = m_q.pop_front();
        if (wr) m_q.push_back(data_in);
        if (counter_in_upd) begin
            m_word   = take ? nxt : '0;
            m_und    = m_und || !take;
            m_k      = 0;
            m_trgt   = int'(counter_in);
            m_lanes  = lanes_of(mode_in);
            m_active = 1'b1;
        end else if (m_active) begin
            if (m_k != m_trgt) begin
                m_k++;
            end else if (take) begin
                m_word = nxt;
                m_k    = 0;
            end else begin
                m_k++;        // sreg shifts once more, then holds in IDLE
                m_active = 1'b0;
            end
        end
        #1;
        check_state_outputs();
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit upd,
                         input int cnt, input logic [1:0] m);
        data_valid     = v;
        data_in        = d;
        counter_in_upd = upd;
        counter_in     = CW'(cnt);
        mode_in        = m;
    endtask

    task automatic idle_ticks(input int n);
        drive(1'b0, '0, 1'b0, 0, 2'b00);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset taking effect between edges.
    task automatic do_reset();
        cs = 1'b1;
        #1;
        check_eq("rst_sdo", {60'd0, sdo}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_ready", {63'd0, data_ready}, 64'd1);
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        check_eq("rst_underrun", {63'd0, underrun}, 64'd0);
`endif
        model_reset();
        @(posedge sclk);
        #1;
        cs = 1'b0;
    endtask

    initial begin
        cs = 1'b1;
        drive(1'b0, '0, 1'b0, 0, 2'b00);
        model_reset();
        @(posedge sclk);
        #1;
        do_reset();
        check_state_outputs();

        // Single lane 0xA5000000, 8 cycles.
        drive(1'b1, 32'hA500_0000, 1'b0, 0, 2'b00); tick();
        drive(1'b0, '0, 1'b1, 7, 2'b00);            tick();
        idle_ticks(10);

        // Quad 0x12345678.
        drive(1'b1, 32'h1234_5678, 1'b0, 0, 2'b00); tick();
        drive(1'b0, '0, 1'b1, 7, 2'b10);            tick();
        idle_ticks(10);

        // Dual streaming, second word written while the first shifts.
        drive(1'b1, 32'hFFFF_0000, 1'b0, 0, 2'b00); tick();
        drive(1'b0, '0, 1'b1, 15, 2'b01);           tick();
        drive(1'b1, 32'h0000_FFFF, 1'b0, 0, 2'b00); tick();
        drive(1'b1, 32'h5555_AAAA, 1'b0, 0, 2'b00); tick();
        idle_ticks(36);

        // Underrun start with empty buffer.
        drive(1'b0, '0, 1'b1, 5, 2'b10); tick();
        idle_ticks(8);

        // Reset mid-word with a buffered word, then an underrun start.
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 0, 2'b00); tick();
        drive(1'b0, '0, 1'b1, 7, 2'b00);            tick();
        drive(1'b1, 32'hCAFE_F00D, 1'b0, 0, 2'b00); tick();
        idle_ticks(2);
        do_reset();
        drive(1'b0, '0, 1'b1, 7, 2'b00); tick();
        idle_ticks(9);

        // Restart mid-word onto the buffered word.
        drive(1'b1, 32'hF0F0_F0F0, 1'b0, 0, 2'b00); tick();
        drive(1'b0, '0, 1'b1, 7, 2'b00);            tick();
        drive(1'b1, 32'h1234_5678, 1'b0, 0, 2'b00); tick();
        idle_ticks(4);
        drive(1'b0, '0, 1'b1, 3, 2'b00); tick();
        idle_ticks(6);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] m;
            bit         upd;
            int         cnt;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                continue;
            end
            m   = 2'($urandom_range(0, 3));
            upd = m_active ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
            cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, W / lanes_of(m) - 1));
            drive(($urandom_range(0, 2) != 0), W'($urandom), upd, cnt, m);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
